// File: rtl/cache_tag_ctrl.sv
// ============================================================================
// Module   : cache_tag_ctrl
// Purpose  : Lookup/fill controller for an 8-way fully-associative 24-bit tag
//            array; owns per-way valid bits and tree pseudo-LRU state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_tag_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [23:0] req_tag,
    output logic        req_ready,
    input  logic        flush,
    input  logic [23:0] tagOut0,
    input  logic [23:0] tagOut1,
    input  logic [23:0] tagOut2,
    input  logic [23:0] tagOut3,
    input  logic [23:0] tagOut4,
    input  logic [23:0] tagOut5,
    input  logic [23:0] tagOut6,
    input  logic [23:0] tagOut7,
    output logic [7:0]  we,
    output logic [23:0] tag_wr,
    output logic        mem_req,
    output logic [23:0] mem_tag,
    input  logic        mem_ack,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_hit,
    output logic [2:0]  resp_way
);

    localparam int c_WAYS = 8;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_COMPARE = 3'd1;
    localparam logic [2:0] c_MISS    = 3'd2;
    localparam logic [2:0] c_WRITE   = 3'd3;
    localparam logic [2:0] c_RESP    = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [23:0] r_tag;
    logic [7:0]  r_valid;
    logic [6:0]  r_plru;
    logic [2:0]  r_way;
    logic        r_hit;

    logic [23:0] w_tag_out [c_WAYS];
    logic [7:0]  w_match;
    logic        w_hit;
    logic [2:0]  w_hit_way;
    logic [2:0]  w_inv_way;
    logic        w_any_inv;
    logic [2:0]  w_plru_victim;

    assign w_tag_out[0] = tagOut0;
    assign w_tag_out[1] = tagOut1;
    assign w_tag_out[2] = tagOut2;
    assign w_tag_out[3] = tagOut3;
    assign w_tag_out[4] = tagOut4;
    assign w_tag_out[5] = tagOut5;
    assign w_tag_out[6] = tagOut6;
    assign w_tag_out[7] = tagOut7;

    generate
        for (genvar i = 0; i < c_WAYS; i++) begin : g_match
            assign w_match[i] = r_valid[i] && (w_tag_out[i] == r_tag);
        end
    endgenerate

    assign w_hit     = |w_match;
    assign w_any_inv = ~&r_valid;

    // Scanning downward leaves the lowest matching / invalid index.
    always_comb begin
        w_hit_way = 3'd0;
        w_inv_way = 3'd0;
        for (int i = c_WAYS - 1; i >= 0; i--) begin
            if (w_match[i]) w_hit_way = 3'(i);
            if (!r_valid[i]) w_inv_way = 3'(i);
        end
    end

    function automatic logic [6:0] plru_touch(input logic [6:0] p, input logic [2:0] w);
        logic [6:0] n;
        n    = p;
        n[0] = ~w[2];
        if (w[2]) n[2] = ~w[1];
        else      n[1] = ~w[1];
        case (w[2:1])
            2'd0:    n[3] = ~w[0];
            2'd1:    n[4] = ~w[0];
            2'd2:    n[5] = ~w[0];
            default: n[6] = ~w[0];
        endcase
        return n;
    endfunction

    always_comb begin
        logic v2;
        logic v1;
        logic v0;
        v2 = r_plru[0];
        v1 = v2 ? r_plru[2] : r_plru[1];
        case ({v2, v1})
            2'd0:    v0 = r_plru[3];
            2'd1:    v0 = r_plru[4];
            2'd2:    v0 = r_plru[5];
            default: v0 = r_plru[6];
        endcase
        w_plru_victim = {v2, v1, v0};
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        we          = 8'h00;
        tag_wr      = 24'h0;
        mem_req     = 1'b0;
        mem_tag     = 24'h0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        resp_way    = 3'd0;
        case (r_state)
            c_IDLE: begin
                req_ready = reset;
                if (!flush && req_valid) w_state_nxt = c_COMPARE;
            end
            c_COMPARE: begin
                w_state_nxt = w_hit ? c_RESP : c_MISS;
            end
            c_MISS: begin
                mem_req = 1'b1;
                mem_tag = r_tag;
                if (mem_ack) w_state_nxt = c_WRITE;
            end
            c_WRITE: begin
                we          = 8'h01 << r_way;
                tag_wr      = r_tag;
                w_state_nxt = c_RESP;
            end
            c_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = r_hit;
                resp_way   = r_way;
                if (resp_ready) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // r_way carries the hit way or, on a miss, the chosen victim through WRITE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag   <= 24'h0;
            r_valid <= 8'h00;
            r_plru  <= 7'h00;
            r_way   <= 3'd0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (flush) begin
                        r_valid <= 8'h00;
                        r_plru  <= 7'h00;
                    end else if (req_valid) begin
                        r_tag <= req_tag;
                    end
                end
                c_COMPARE: begin
                    if (w_hit) begin
                        r_hit  <= 1'b1;
                        r_way  <= w_hit_way;
                        r_plru <= plru_touch(r_plru, w_hit_way);
                    end else begin
                        r_hit <= 1'b0;
                        r_way <= w_any_inv ? w_inv_way : w_plru_victim;
                    end
                end
                c_WRITE: begin
                    r_valid[r_way] <= 1'b1;
                    r_plru         <= plru_touch(r_plru, r_way);
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_tag_ctrl.sv
// ============================================================================
// Module   : tb_cache_tag_ctrl
// Purpose  : Scoreboard bench for cache_tag_ctrl with a negedge-write tag
//            array model and a delayed-ack memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_tag_ctrl;

    typedef struct packed {
        logic       hit;
        logic [2:0] way;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [23:0] req_tag;
    logic        req_ready;
    logic        flush;
    logic [23:0] tagOut0, tagOut1, tagOut2, tagOut3;
    logic [23:0] tagOut4, tagOut5, tagOut6, tagOut7;
    logic [7:0]  we;
    logic [23:0] tag_wr;
    logic        mem_req;
    logic [23:0] mem_tag;
    logic        mem_ack;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [2:0]  resp_way;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];
    exp_t e;

    logic [23:0] arr [8];
    int   ack_delay;
    logic ack_en;
    logic auto_ack;
    logic manual_ack;
    int   mreq_cnt;

    logic       got_hit;
    logic [2:0] got_way;
    int         lat;
    logic       saw_mreq;
    int         we_cnt;
    logic [7:0] we_seen;
    logic [23:0] tagwr_seen;
    logic       timed_out;
    logic       stable;

    cache_tag_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .flush(flush),
        .tagOut0(tagOut0), .tagOut1(tagOut1), .tagOut2(tagOut2), .tagOut3(tagOut3),
        .tagOut4(tagOut4), .tagOut5(tagOut5), .tagOut6(tagOut6), .tagOut7(tagOut7),
        .we(we), .tag_wr(tag_wr),
        .mem_req(mem_req), .mem_tag(mem_tag), .mem_ack(mem_ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_way(resp_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag array: captures writes on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++)
            if (we[i]) arr[i] <= tag_wr;
    end
    assign tagOut0 = arr[0];
    assign tagOut1 = arr[1];
    assign tagOut2 = arr[2];
    assign tagOut3 = arr[3];
    assign tagOut4 = arr[4];
    assign tagOut5 = arr[5];
    assign tagOut6 = arr[6];
    assign tagOut7 = arr[7];

    // Memory side: ack after mem_req has been seen for ack_delay samples.
    always @(negedge clk) begin
        if (mem_req && ack_en) begin
            mreq_cnt = mreq_cnt + 1;
            auto_ack = (mreq_cnt == ack_delay);
        end else begin
            mreq_cnt = 0;
            auto_ack = 1'b0;
        end
    end
    assign mem_ack = auto_ack | manual_ack;

    task automatic reset_dut();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic issue(input logic [23:0] t, input int hold);
        req_valid = 1'b1;
        req_tag   = t;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; saw_mreq = 1'b0; we_cnt = 0; we_seen = 8'h00;
        tagwr_seen = 24'h0; timed_out = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            lat++;
            if (mem_req) saw_mreq = 1'b1;
            if (we !== 8'h00) begin
                we_cnt++;
                we_seen    = we;
                tagwr_seen = tag_wr;
            end
            if (resp_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        got_hit = resp_hit;
        got_way = resp_way;
        stable  = (req_ready === 1'b0);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_hit !== got_hit ||
                resp_way !== got_way || req_ready !== 1'b0) stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (we !== 8'h00) begin errors++; $display("FAIL rst_we: got %0h expected 0", we); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0b expected 0", mem_req); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0b expected 0", resp_valid); end
        checks++; if ({resp_hit, resp_way} !== 4'h0) begin errors++; $display("FAIL rst_resp: got %0h expected 0", {resp_hit, resp_way}); end
        checks++; if (tag_wr !== 24'h0 || mem_tag !== 24'h0) begin errors++; $display("FAIL rst_tags: got %0h/%0h expected 0/0", tag_wr, mem_tag); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready_low: got %0b expected 0", req_ready); end
        checks++; if (dut.r_valid !== 8'h00 || dut.r_plru !== 7'h00) begin errors++; $display("FAIL rst_state: valid %0h plru %0h expected 0/0", dut.r_valid, dut.r_plru); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b expected 1", req_ready); end
    endtask

    task automatic test_cold_miss();
        @(posedge clk); #1;
        ack_delay = 3;
        sb.push_back('{hit: 1'b0, way: 3'd0});
        issue(24'h00ABCD, 0);
        e = sb.pop_front();
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL cold_timeout: got %0b expected 0", timed_out); end
        checks++; if (got_hit !== e.hit || got_way !== e.way) begin errors++; $display("FAIL cold_resp: got hit=%0b way=%0d expected hit=%0b way=%0d", got_hit, got_way, e.hit, e.way); end
        checks++; if (we_cnt !== 1 || we_seen !== 8'h01) begin errors++; $display("FAIL cold_we: got cnt=%0d we=%0h expected cnt=1 we=01", we_cnt, we_seen); end
        checks++; if (tagwr_seen !== 24'h00ABCD) begin errors++; $display("FAIL cold_tag_wr: got %0h expected abcd", tagwr_seen); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL cold_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_repeat_hit();
        sb.push_back('{hit: 1'b1, way: 3'd0});
        issue(24'h00ABCD, 0);
        e = sb.pop_front();
        checks++; if (got_hit !== e.hit || got_way !== e.way) begin errors++; $display("FAIL hit_resp: got hit=%0b way=%0d expected hit=%0b way=%0d", got_hit, got_way, e.hit, e.way); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", lat); end
        checks++; if (saw_mreq !== 1'b0 || we_cnt !== 0) begin errors++; $display("FAIL hit_side_effects: got mem_req=%0b we_cnt=%0d expected 0/0", saw_mreq, we_cnt); end
    endtask

    task automatic test_plru();
        logic [23:0] tags [3];
        exp_t        exps [3];
        reset_dut();
        ack_delay = 1;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{hit: 1'b0, way: 3'(i)});
            issue(24'h000010 + 24'(i), 0);
            e = sb.pop_front();
            checks++; if (got_hit !== e.hit || got_way !== e.way) begin errors++; $display("FAIL fill_%0d: got hit=%0b way=%0d expected hit=%0b way=%0d", i, got_hit, got_way, e.hit, e.way); end
        end
        tags[0] = 24'h000020; exps[0] = '{hit: 1'b0, way: 3'd0};
        tags[1] = 24'h000011; exps[1] = '{hit: 1'b1, way: 3'd1};
        tags[2] = 24'h000030; exps[2] = '{hit: 1'b0, way: 3'd4};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exps[i]);
            issue(tags[i], 0);
            e = sb.pop_front();
            checks++; if (got_hit !== e.hit || got_way !== e.way) begin errors++; $display("FAIL plru_%0h: got hit=%0b way=%0d expected hit=%0b way=%0d", tags[i], got_hit, got_way, e.hit, e.way); end
            checks++; if (we_seen !== (e.hit ? 8'h00 : (8'h01 << e.way))) begin errors++; $display("FAIL plru_we_%0h: got %0h expected way %0d", tags[i], we_seen, e.way); end
        end
    endtask

    task automatic test_flush();
        logic quiet;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{hit: 1'b0, way: 3'(i)});
            issue(24'h000010 + 24'(i), 0);
            e = sb.pop_front();
            checks++; if (got_way !== e.way) begin errors++; $display("FAIL flush_prefill_%0d: got way=%0d expected %0d", i, got_way, e.way); end
        end
        flush = 1'b1; req_valid = 1'b1; req_tag = 24'h000011;
        @(posedge clk);
        #1 flush = 1'b0; req_valid = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL flush_no_accept: got %0b expected 1", quiet); end
        sb.push_back('{hit: 1'b0, way: 3'd0});
        issue(24'h000012, 0);
        e = sb.pop_front();
        checks++; if (got_hit !== e.hit || got_way !== e.way || saw_mreq !== 1'b1) begin errors++; $display("FAIL flush_refill: got hit=%0b way=%0d mreq=%0b expected hit=0 way=0 mreq=1", got_hit, got_way, saw_mreq); end
    endtask

    task automatic test_reset_mid_miss();
        logic seen;
        logic quiet;
        reset_dut();
        sb.push_back('{hit: 1'b0, way: 3'd0});
        issue(24'h000040, 0);
        e = sb.pop_front();
        checks++; if (got_way !== e.way || got_hit !== e.hit) begin errors++; $display("FAIL rmm_prefill: got hit=%0b way=%0d expected hit=0 way=0", got_hit, got_way); end
        ack_en = 1'b0;
        req_valid = 1'b1; req_tag = 24'h000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rmm_mem_req: got %0b expected 1", seen); end
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1; manual_ack = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmm_mem_req_drop: got %0b expected 0", mem_req); end
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) manual_ack = 1'b0;
            @(negedge clk);
            if (we !== 8'h00 || resp_valid !== 1'b0 || mem_req !== 1'b0) quiet = 1'b0;
        end
        manual_ack = 1'b0;
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rmm_late_ack: got %0b expected 1", quiet); end
        checks++; if (req_ready !== 1'b1 || dut.r_valid !== 8'h00) begin errors++; $display("FAIL rmm_idle: got ready=%0b valid=%0h expected 1/00", req_ready, dut.r_valid); end
        ack_en = 1'b1;
        sb.push_back('{hit: 1'b0, way: 3'd0});
        issue(24'h000040, 0);
        e = sb.pop_front();
        checks++; if (got_hit !== e.hit || got_way !== e.way || saw_mreq !== 1'b1) begin errors++; $display("FAIL rmm_refetch: got hit=%0b way=%0d mreq=%0b expected hit=0 way=0 mreq=1", got_hit, got_way, saw_mreq); end
    endtask

    task automatic test_backpressure();
        sb.push_back('{hit: 1'b1, way: 3'd0});
        issue(24'h000040, 5);
        e = sb.pop_front();
        checks++; if (got_hit !== e.hit || got_way !== e.way) begin errors++; $display("FAIL bp_resp: got hit=%0b way=%0d expected hit=%0b way=%0d", got_hit, got_way, e.hit, e.way); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %0b expected 1", stable); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%0b valid=%0b expected 1/0", req_ready, resp_valid); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_tag = 24'h0; flush = 1'b0;
        resp_ready = 1'b0; manual_ack = 1'b0; ack_en = 1'b1; ack_delay = 1;
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_plru();
        test_flush();
        test_reset_mid_miss();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Lookup/fill controller for the 8-way, 24-bit tag array (`tagArray`), managed as a single fully-associative set of 8 entries.
- Accepts tag lookup requests, compares them against all eight array outputs, and returns hit/miss plus way.
- On a miss, selects a victim (first invalid way, else 3-level tree pseudo-LRU), requests the fill from the memory side, and writes the tag into the victim way through the array's per-way write enables.
- Owns the per-way valid bits and the PLRU state; the array holds tags only.

## Interface
Parameters: none (8 ways, 24-bit tag fixed by the array).

Ports:
- clk  in  1  clock; all controller state on posedge
- reset  in  1  synchronous, active-low reset (sampled on posedge clk)
- req_valid  in  1  lookup request
- req_tag  in  24  tag to look up
- req_ready  out  1  controller can accept a request (IDLE only)
- flush  in  1  invalidate all ways; sampled in IDLE only
- tagOut0 … tagOut7  in  24 each  tag array read data, ways 0–7
- we  out  8  one-hot per-way write enable to the array
- tag_wr  out  24  write data to the array
- mem_req  out  1  fill request, held until mem_ack
- mem_tag  out  24  tag being filled
- mem_ack  in  1  fill complete
- resp_valid  out  1  response available, held until resp_ready
- resp_ready  in  1  consumer takes the response
- resp_hit  out  1  1 = hit, 0 = miss that was filled
- resp_way  out  3  way that hit or was filled

## Operation
- Reset (reset=0 at posedge, in any state):
  - Next state IDLE; valid[7:0]=0; plru[6:0]=0.
  - we=0, mem_req=0, resp_valid=0, resp_hit=0, resp_way=0, tag_wr=0, mem_tag=0.
  - req_ready=1 once reset=1.
- IDLE:
  - flush=1: valid←0, plru←0; stay in IDLE. flush has priority over req_valid.
  - Otherwise req_valid=1: latch req_tag; go to COMPARE.
- COMPARE:
  - match[i] = valid[i] && (tagOut_i == latched tag).
  - Any match: way = lowest matching index; update PLRU; go to RESP with hit=1.
  - No match: victim = lowest invalid way if any valid bit is 0, else the PLRU victim; go to MISS.
- MISS:
  - mem_req=1, mem_tag = latched tag.
  - mem_ack=1: go to WRITE. mem_ack in any other state is ignored.
- WRITE (exactly 1 cycle):
  - we = one-hot(victim), tag_wr = latched tag.
  - valid[victim]←1; update PLRU with the victim; go to RESP with hit=0, way=victim.
- RESP:
  - resp_valid=1, resp_hit and resp_way stable.
  - resp_ready=1: go to IDLE.
- PLRU update on access to way w:
  - plru[0]←~w[2]
  - plru[1+w[2]]←~w[1]
  - plru[3+2·w[2]+w[1]]←~w[0]
- PLRU victim:
  - v2=plru[0]
  - v1=plru[1+v2]
  - v0=plru[3+2·v2+v1]

## Timing
- The array writes on negedge clk. `we` asserted in the WRITE cycle is captured mid-cycle, and the new tag is visible on tagOut by the next posedge.
- Hit: request accepted at edge N → COMPARE in cycle N+1 → resp_valid from edge N+2. Minimum 2-cycle latency.
- Miss: mem_req rises at edge N+2. mem_ack sampled at edge M → WRITE in cycle M+1 → resp_valid from edge M+2.
- One request in flight. req_ready=0 in every state except IDLE.
- A new request may be accepted on the edge after the RESP handshake completes.
- Reset during MISS: mem_req drops at the next edge. A late mem_ack is ignored. No array write occurs.
- Reset during WRITE: the same-cycle negedge write may still land in the array, but valid is cleared, so the entry is dead.

## Test plan
- Reset: hold reset=0 for 2 cycles → all outputs 0, valid=0, plru=0; after release, req_ready=1.
- Cold miss: req_tag=0x00ABCD, mem_ack 3 cycles after mem_req → we=0x01 for 1 cycle, tag_wr=0x00ABCD; resp_valid with hit=0, way=0.
- Repeat hit: request 0x00ABCD again → resp_valid 2 cycles after acceptance, hit=1, way=0, mem_req never asserted.
- PLRU replacement:
  - Fill tags 0x000010–0x000017 → ways 0–7 in order.
  - Miss 0x000020 → victim way 0.
  - Then hit 0x000011 (way 1), miss 0x000030 → victim way 4.
- Flush: flush=1 in IDLE with req_valid=1 → no request accepted; then request 0x000012 → miss, fills way 0.
- Reset mid-miss: reset=0 while mem_req=1, then mem_ack=1 → no we pulse, no resp_valid, state IDLE, valid=0.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid, hit and way stable; req_ready=0 throughout.
